// File: rtl/ov7670_capture.sv
// OV7670 capture stage: oversamples the camera bus in the ACLK domain, pairs bytes
// into RGB565 pixels and streams them out through a small first-word-fall-through FIFO.
module ov7670_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 12
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cam_pclk,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  input  logic             capture_en,
  input  logic             single_shot,
  output logic [15:0]      m_pix_data,
  output logic             m_pix_valid,
  input  logic             m_pix_ready,
  output logic             m_pix_sof,
  output logic             m_pix_eol,
  output logic [31:0]      frame_count,
  output logic [CNT_W-1:0] line_pixels,
  output logic [CNT_W-1:0] frame_lines,
  output logic             overflow,
  output logic             busy,
  output logic             frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [10:0] sync_q [SYNC_STAGES];
  logic [2:0]  hist_q;
  logic [10:0] cam_s;
  logic        pclk_evt, vs_rise, vs_fall, href_fall;

  logic [1:0]       state_q, state_d;
  logic             shot_done_q, phase_q, first_pix_q;
  logic             pend_vld_q, pend_sof_q;
  logic [7:0]       hi_q;
  logic [15:0]      pend_data_q;
  logic [CNT_W-1:0] pix_cnt_q, line_cnt_q, line_pixels_q, frame_lines_q;
  logic [31:0]      frame_count_q;
  logic             act, start, byte_evt, pix_done, line_end, push;
  logic [17:0]      push_word;

  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, pop, push_ok, ovf_q;
  logic [17:0]   head;

  // Input synchronizers plus one history flop for edge detection
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= {cam_pclk, cam_vsync, cam_href, cam_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1][10:8];
    end
  end

  assign cam_s     = sync_q[SYNC_STAGES-1];
  assign pclk_evt  = cam_s[10] & ~hist_q[2];
  assign vs_rise   = cam_s[9] & ~hist_q[1];
  assign vs_fall   = ~cam_s[9] & hist_q[1];
  assign href_fall = ~cam_s[8] & hist_q[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (capture_en && !shot_done_q) state_d = S_WAIT_VS;
      S_WAIT_VS: if (!capture_en) state_d = S_IDLE;
                 else if (vs_fall) state_d = S_ACTIVE;
      S_ACTIVE:  if (!capture_en) state_d = S_IDLE;
                 else if (vs_rise) state_d = S_DONE;
      default:   state_d = single_shot ? S_IDLE : S_WAIT_VS;
    endcase
  end

  assign act      = (state_q == S_ACTIVE) && capture_en;
  assign start    = (state_q == S_WAIT_VS) && (state_d == S_ACTIVE);
  assign byte_evt = act && pclk_evt && cam_s[8];
  assign pix_done = byte_evt && phase_q;
  assign line_end = act && href_fall;
  // A completed pixel waits in pend_* until the next one completes or the line
  // ends, so its eol tag is already known when it enters the FIFO.
  assign push      = (pix_done || line_end) && pend_vld_q;
  assign push_word = {pend_sof_q, line_end, pend_data_q};

  // Byte pairing, line/frame accounting and FSM state
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= S_IDLE;
      shot_done_q   <= 1'b0;
      phase_q       <= 1'b0;
      first_pix_q   <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_sof_q    <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_pixels_q <= '0;
      frame_lines_q <= '0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        phase_q     <= 1'b0;
        pend_vld_q  <= 1'b0;
        first_pix_q <= 1'b1;
        pix_cnt_q   <= '0;
        line_cnt_q  <= '0;
      end else if (byte_evt) begin
        phase_q <= ~phase_q;
        if (phase_q) begin
          pend_vld_q  <= 1'b1;
          pend_sof_q  <= first_pix_q;
          first_pix_q <= 1'b0;
          if (pix_cnt_q != CNT_MAX) pix_cnt_q <= pix_cnt_q + CNT_W'(1);
        end
      end else if (line_end) begin
        phase_q    <= 1'b0;
        pend_vld_q <= 1'b0;
        if (pix_cnt_q != '0) begin
          line_pixels_q <= pix_cnt_q;
          pix_cnt_q     <= '0;
          if (line_cnt_q != CNT_MAX) line_cnt_q <= line_cnt_q + CNT_W'(1);
        end
      end
      if (state_q == S_DONE) begin
        frame_count_q <= frame_count_q + 32'd1;
        frame_lines_q <= line_cnt_q;
      end
      // A finished single shot stays parked in IDLE until capture_en is dropped.
      if (state_q == S_DONE && single_shot) shot_done_q <= 1'b1;
      else if (!capture_en)                 shot_done_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (byte_evt && !phase_q) hi_q <= cam_s[7:0];
    if (pix_done)             pend_data_q <= {hi_q, cam_s[7:0]};
  end

  // Pixel FIFO
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && m_pix_ready;
  assign push_ok = push && (!full || pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (AW+1)'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign m_pix_valid = !empty;
  assign m_pix_data  = empty ? 16'h0000 : head[15:0];
  assign m_pix_sof   = !empty && head[17];
  assign m_pix_eol   = !empty && head[16];
  assign frame_count = frame_count_q;
  assign line_pixels = line_pixels_q;
  assign frame_lines = frame_lines_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: drives whole camera frames and scoreboards the pixel
// stream and counters against a frame-level model built from the byte tables.
module tb_ov7670_capture;
  logic        ACLK = 1'b0;
  logic        ARESET, cam_pclk, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        capture_en, single_shot, m_pix_ready;
  logic [15:0] m_pix_data;
  logic        m_pix_valid, m_pix_sof, m_pix_eol, overflow, busy, frame_done;
  logic [31:0] frame_count;
  logic [11:0] line_pixels, frame_lines;

  ov7670_capture #(.SYNC_STAGES(2), .FIFO_DEPTH(4), .CNT_W(12)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .capture_en(capture_en),
    .single_shot(single_shot), .m_pix_data(m_pix_data), .m_pix_valid(m_pix_valid),
    .m_pix_ready(m_pix_ready), .m_pix_sof(m_pix_sof), .m_pix_eol(m_pix_eol),
    .frame_count(frame_count), .line_pixels(line_pixels), .frame_lines(frame_lines),
    .overflow(overflow), .busy(busy), .frame_done(frame_done)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_fail = 0;
  logic [17:0] exp_q [$];
  logic [17:0] mon_e;
  int exp_frames = 0, exp_lp = 0, exp_fl = 0, done_cnt = 0;
  bit rnd_rdy = 1'b0;
  logic [7:0] fb [8][16];
  int flen [8];
  int fnl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  always @(posedge ACLK) begin
    #2;
    if (rnd_rdy) m_pix_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (frame_done) done_cnt++;
      if (m_pix_valid && m_pix_ready) begin
        if (exp_q.size() == 0) chk("pix_extra", 32'(exp_q.size()), 32'd1);
        else begin
          mon_e = exp_q.pop_front();
          chk("pix_data", 32'(m_pix_data), 32'(mon_e[15:0]));
          chk("pix_sof", 32'(m_pix_sof), 32'(mon_e[17]));
          chk("pix_eol", 32'(m_pix_eol), 32'(mon_e[16]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout after %0d checks, expected completion", n_chk);
    $fatal(1, "timeout");
  end

  task automatic set_ready(input bit r, input logic v);
    @(posedge ACLK);
    #2;
    rnd_rdy = r;
    m_pix_ready = v;
  endtask

  task automatic pclk_cycle(input logic [7:0] d, input logic h);
    cam_data = d;
    cam_href = h;
    repeat (4) @(negedge ACLK);
    cam_pclk = 1'b1;
    repeat (4) @(negedge ACLK);
    cam_pclk = 1'b0;
  endtask

  task automatic rand_frame();
    fnl = $urandom_range(1, 4);
    for (int l = 0; l < fnl; l++) begin
      flen[l] = $urandom_range(0, 12);
      for (int b = 0; b < 16; b++) fb[l][b] = 8'($urandom);
    end
  endtask

  // Model: pixel p of a line is bytes {2p, 2p+1}; the last whole pixel carries eol,
  // the first pixel of the frame carries sof. cap limits what fits in the FIFO;
  // an abort after ab_byte bytes keeps only pixels whose successor had completed.
  task automatic drive_frame(input bit capt, input int cap, input int ab_line, input int ab_byte);
    int pushed, lines;
    bit first;
    pushed = 0; lines = 0; first = 1'b1;
    cam_vsync = 1'b0;
    repeat (3) pclk_cycle(8'h00, 1'b0);
    for (int l = 0; l < fnl; l++) begin
      int np, lim;
      np  = flen[l] / 2;
      lim = (l == ab_line) ? ab_byte / 2 - 1 : np;
      if (capt && (ab_line < 0 || l <= ab_line)) begin
        for (int p = 0; p < lim; p++) begin
          if (cap < 0 || pushed < cap)
            exp_q.push_back({first, (p == np - 1), fb[l][2*p], fb[l][2*p+1]});
          pushed++;
          first = 1'b0;
        end
        if (l != ab_line && np > 0) begin
          exp_lp = np;
          lines++;
        end
      end
      for (int b = 0; b < flen[l]; b++) begin
        pclk_cycle(fb[l][b], 1'b1);
        if (l == ab_line && b == ab_byte - 1) capture_en = 1'b0;
      end
      repeat (2) pclk_cycle(8'h00, 1'b0);
    end
    cam_vsync = 1'b1;
    repeat (3) pclk_cycle(8'h00, 1'b0);
    if (capt && ab_line < 0) begin
      exp_frames++;
      exp_fl = lines;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_pix_valid) && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(m_pix_valid), 32'd0);
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_frame_count"}, frame_count, 32'(exp_frames));
    chk({tag, "_frame_lines"}, 32'(frame_lines), 32'(exp_fl));
    chk({tag, "_line_pixels"}, 32'(line_pixels), 32'(exp_lp));
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_frames));
  endtask

  initial begin
    ARESET = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    capture_en = 1'b0; single_shot = 1'b0; m_pix_ready = 1'b0;
    repeat (4) @(negedge ACLK);
    chk("rst_valid", 32'(m_pix_valid), 32'd0);
    chk("rst_data", 32'(m_pix_data), 32'd0);
    chk("rst_sof", 32'(m_pix_sof), 32'd0);
    chk("rst_eol", 32'(m_pix_eol), 32'd0);
    chk("rst_frame_count", frame_count, 32'd0);
    chk("rst_line_pixels", 32'(line_pixels), 32'd0);
    chk("rst_frame_lines", 32'(frame_lines), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    ARESET = 1'b0;

    // Basic frame: 2 lines x 4 pixels, bytes 0x01..0x10, ready held high
    set_ready(1'b0, 1'b1);
    capture_en = 1'b1;
    repeat (4) @(negedge ACLK);
    fnl = 2; flen[0] = 8; flen[1] = 8;
    for (int l = 0; l < 2; l++)
      for (int b = 0; b < 8; b++) fb[l][b] = 8'(l * 8 + b + 1);
    drive_frame(1'b1, -1, -1, 0);
    wait_drain();
    chk("basic_line_pixels", 32'(line_pixels), 32'd4);
    chk("basic_frame_lines", 32'(frame_lines), 32'd2);
    chk("basic_frame_count", frame_count, 32'd1);
    chk("basic_done_pulses", 32'(done_cnt), 32'd1);
    chk("basic_busy", 32'(busy), 32'd1);

    // Random frames with random consumer backpressure
    set_ready(1'b1, 1'b1);
    repeat (4) begin
      rand_frame();
      drive_frame(1'b1, -1, -1, 0);
      wait_drain();
      frame_checks("rnd");
    end

    // Odd byte count: trailing byte dropped
    fnl = 1; flen[0] = 7;
    for (int b = 0; b < 16; b++) fb[0][b] = 8'($urandom);
    drive_frame(1'b1, -1, -1, 0);
    wait_drain();
    chk("odd_line_pixels", 32'(line_pixels), 32'd3);
    chk("odd_frame_lines", 32'(frame_lines), 32'd1);

    // Backpressure: 6-pixel line into a 4-entry FIFO with ready low
    chk("bp_overflow_before", 32'(overflow), 32'd0);
    set_ready(1'b0, 1'b0);
    fnl = 1; flen[0] = 12;
    for (int b = 0; b < 16; b++) fb[0][b] = 8'($urandom);
    drive_frame(1'b1, 4, -1, 0);
    chk("bp_valid_held", 32'(m_pix_valid), 32'd1);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_line_pixels", 32'(line_pixels), 32'd6);
    set_ready(1'b0, 1'b1);
    wait_drain();
    chk("bp_overflow_sticky", 32'(overflow), 32'd1);

    // Abort in the middle of line 2, then recapture
    set_ready(1'b1, 1'b1);
    fnl = 3; flen[0] = 8; flen[1] = 8; flen[2] = 8;
    for (int l = 0; l < 3; l++)
      for (int b = 0; b < 16; b++) fb[l][b] = 8'($urandom);
    drive_frame(1'b1, -1, 1, 5);
    wait_drain();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_frame_count", frame_count, 32'(exp_frames));
    chk("abort_done_pulses", 32'(done_cnt), 32'(exp_frames));
    chk("abort_frame_lines", 32'(frame_lines), 32'(exp_fl));
    capture_en = 1'b1;
    repeat (4) @(negedge ACLK);
    rand_frame();
    drive_frame(1'b1, -1, -1, 0);
    wait_drain();
    frame_checks("recapture");

    // Single shot: only the first of three frames is captured
    single_shot = 1'b1;
    rand_frame();
    drive_frame(1'b1, -1, -1, 0);
    chk("ss_busy_after_first", 32'(busy), 32'd0);
    repeat (2) begin
      rand_frame();
      drive_frame(1'b0, -1, -1, 0);
      chk("ss_busy_idle", 32'(busy), 32'd0);
    end
    wait_drain();
    frame_checks("single_shot");

    // Reset in the middle of line 1 with a pixel waiting in the FIFO
    single_shot = 1'b0;
    capture_en = 1'b0;
    repeat (2) @(negedge ACLK);
    capture_en = 1'b1;
    set_ready(1'b0, 1'b0);
    cam_vsync = 1'b0;
    repeat (3) pclk_cycle(8'h00, 1'b0);
    for (int b = 0; b < 5; b++) pclk_cycle(8'hA0 + 8'(b), 1'b1);
    chk("mid_valid_before_reset", 32'(m_pix_valid), 32'd1);
    @(posedge ACLK);
    #2;
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mid_rst_valid", 32'(m_pix_valid), 32'd0);
    chk("mid_rst_data", 32'(m_pix_data), 32'd0);
    chk("mid_rst_frame_count", frame_count, 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_line_pixels", 32'(line_pixels), 32'd0);
    chk("mid_rst_frame_lines", 32'(frame_lines), 32'd0);
    ARESET = 1'b0;
    exp_q.delete();
    exp_frames = 0; exp_lp = 0; exp_fl = 0; done_cnt = 0;
    for (int b = 5; b < 8; b++) pclk_cycle(8'hA0 + 8'(b), 1'b1);
    repeat (2) pclk_cycle(8'h00, 1'b0);
    cam_vsync = 1'b1;
    repeat (3) pclk_cycle(8'h00, 1'b0);
    set_ready(1'b1, 1'b1);
    rand_frame();
    flen[0] = 8;
    drive_frame(1'b1, -1, -1, 0);
    wait_drain();
    chk("post_rst_frame_count", frame_count, 32'd1);
    frame_checks("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Camera-side capture stage feeding the OV7670 AXI4-Lite register/control block.
- Oversamples the OV7670 parallel bus (PCLK, VSYNC, HREF, D[7:0]) in the ACLK domain and pairs bytes into RGB565 pixels.
- Pushes pixels through a small FIFO onto a valid/ready pixel stream.
- Exports frame/line counters and status bits to the register block.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of input synchronizers (min 2)
- FIFO_DEPTH, 4, pixel FIFO entries (power of 2, ≥2)
- CNT_W, 12, width of per-line pixel and per-frame line counters

Ports:
- ACLK  in  1  system clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- cam_pclk  in  1  camera pixel clock, asynchronous; must be ≤ ACLK/4
- cam_vsync  in  1  frame sync, active high = vertical blanking
- cam_href  in  1  line valid, active high
- cam_data  in  8  camera data byte
- capture_en  in  1  level enable from control register
- single_shot  in  1  1 = stop after one complete frame
- m_pix_data  out  16  RGB565 pixel; first byte in [15:8]
- m_pix_valid  out  1  pixel available
- m_pix_ready  in  1  consumer accepts when valid&ready
- m_pix_sof  out  1  qualifies first pixel of frame
- m_pix_eol  out  1  qualifies last pixel of line
- frame_count  out  32  completed frames, wraps at 2^32
- line_pixels  out  CNT_W  pixel count of last completed line
- frame_lines  out  CNT_W  line count of last completed frame
- overflow  out  1  sticky; pixel dropped on full FIFO
- busy  out  1  FSM not in IDLE
- frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM = IDLE; byte phase = 0. Synchronizers cleared to 0.
- Input path:
  - cam_* pass through SYNC_STAGES flops, then one history flop.
  - A pclk event is a synchronized 0→1 transition of cam_pclk.
  - vsync/href edges are detected the same way.
  - Data/href are sampled from the synchronized copy aligned with the pclk event.
- FSM:
  - IDLE: capture_en=1 → WAIT_VS.
  - WAIT_VS: synchronized vsync falling edge → ACTIVE; set first_pix flag. capture_en=0 → IDLE.
  - ACTIVE, frame end: vsync rising edge → DONE.
  - ACTIVE, abort: capture_en=0 → IDLE immediately. Partial line/frame is discarded: counters not updated, no frame_done, FIFO contents kept.
  - DONE: one cycle. frame_done=1, frame_count+1, frame_lines latched. Then single_shot=1 → IDLE, else WAIT_VS.
- Byte pairing (ACTIVE only):
  - On pclk event with href=1: phase 0 stores high byte; phase 1 forms {hi, data} and pushes to FIFO. Phase toggles.
  - href falling edge: phase forced to 0 (odd trailing byte discarded). Line counter +1; line_pixels latched from pixel counter, then cleared.
  - Lines with 0 pixels are not counted.
- eol marking: the last pushed pixel of a line gets eol. eol is written into the FIFO tag of the most recent entry when the href falling edge arrives.
  - If that entry already left the FIFO, a zero-pixel marker is never generated. Consumer sees no eol for that line; counters still correct.
  - To keep this rare, the push is delayed one pclk event so eol is known at push time: a pixel is pushed when the next pixel completes or at href fall.
- sof: attached to the first pixel pushed after entering ACTIVE.
- FIFO:
  - Entries 18 bits {sof, eol, data}; first-word fall-through.
  - m_pix_valid = not empty.
  - Push-to-valid latency 1 ACLK.
  - Simultaneous push and pop when full is allowed (pop frees the slot).
- Overflow: push while full and no pop drops the pixel and sets overflow, which stays 1 until ARESET. Counters still count the dropped pixel.
- Counters saturate at 2^CNT_W−1; frame_count wraps.
- ARESET mid-frame: everything returns to reset values the next cycle; stream output drops valid without completing a handshake.

Test Plan:
- Basic frame: capture_en=1; 2 lines × 4 pixels, bytes 0x01..0x10, ready=1. Required:
  - Stream 0x0102, 0x0304, … 0x0F10.
  - sof on 0x0102; eol on 0x0708 and 0x0F10.
  - line_pixels=4, frame_lines=2, frame_count=1, one frame_done pulse.
- Backpressure: ready=0 for a 6-pixel line, FIFO_DEPTH=4 → 4 pixels stored, overflow=1. Then ready=1 → 4 pixels drain in order; line_pixels=6.
- Odd bytes: line of 7 bytes → 3 pixels output; the 7th byte is dropped; line_pixels=3.
- Single-shot: single_shot=1, three frames driven → frame_count=1, busy=0 after the first frame, no further pixels.
- Abort: capture_en cleared mid-line 2 → FSM IDLE, frame_count unchanged, no frame_done. Re-enable captures the next frame with sof.
- Reset mid-frame: ARESET pulse during line 1 → all outputs 0 next cycle. The following frame captures normally with frame_count=1.
